digit_entry_display: RTL and testbench
======================================

Name: digit_entry_display

Overview:
- Parametrised successor to the fixed 8-digit student-ID editor/display pair.
- Holds a DIGITS-wide BCD value edited with cursor buttons (left/right/inc/dec) and supports a parallel preload.
- Drives one multiplexed active-low 7-segment bus with a blinking cursor digit.
- Runs entirely on clk100mhz, using internal tick enables instead of derived clocks; sits between the button edge logic and the board's seven-segment pins.

Parameters:
- DIGITS, 8, number of BCD digits, 2..16.
- SCAN_DIV, 262144, clk100mhz cycles per scan tick; minimum 2.
- BLINK_TICKS, 64, scan ticks per blink half-period; minimum 1.

Ports:
- clk100mhz  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  edit enable; when low, buttons are ignored and blinking is suppressed.
- btn_left  in  1  level, debounced; cursor toward the more-significant digit.
- btn_right  in  1  level, debounced; cursor toward the less-significant digit.
- btn_inc  in  1  level, debounced; increment the digit under the cursor.
- btn_dec  in  1  level, debounced; decrement the digit under the cursor.
- load  in  1  one-cycle strobe; copy load_value into the value register.
- load_value  in  4*DIGITS  BCD preload; digit 0 in [3:0].
- value  out  4*DIGITS  current BCD value, registered.
- cursor  out  $clog2(DIGITS)  current cursor index, registered.
- an  out  DIGITS  digit enables, active-low one-hot.
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset: value=0, cursor=0, scan_idx=0, tick counters=0, blink phase=on, an=all 1s, seg=8'hFF.
- Edge detect: each button has a prev-level register, edge = btn & ~prev. The action takes effect at the clock edge where the button is first sampled high, so outputs change 1 cycle after the rise. Holding a button does not repeat.
- Priority each cycle:
  - load > button actions.
  - Any load_value nibble >9 is stored as 0.
  - load does not move the cursor.
- en=0: button edges are discarded and prev registers still track, so no action fires when en rises with a button already held.
- Simultaneous events:
  - left+right in the same cycle: cursor unchanged.
  - inc+dec in the same cycle: value unchanged.
  - A move plus inc/dec: the digit change applies at the old cursor, and the cursor moves in the same cycle.
- Cursor wrap: left from DIGITS-1 goes to 0; right from 0 goes to DIGITS-1.
- Digit arithmetic (macro off): inc 9→0, dec 0→9, other digits untouched.
- Scan:
  - A tick counter counts 0..SCAN_DIV-1; the tick pulses when the count reaches SCAN_DIV-1.
  - scan_idx increments per tick, wrapping DIGITS-1→0.
- Outputs: an/seg are registered from scan_idx each cycle. The first cycle after reset release gives an=~(1<<0) and seg=encoding of digit 0.
- Encoding, dp always 1:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Blink:
  - The phase toggles every BLINK_TICKS scan ticks.
  - When en=1, phase=off and scan_idx==cursor, seg=8'hFF; an is still driven.
  - When en=0, all digits are always shown.
- Reset mid-operation: all state returns to its reset values on the next edge, and any pending button edge is lost.

Optional Feature:
- Macro: DIGIT_CARRY_EN.
- Defined:
  - inc on 9 sets the digit to 0 and carries +1 into higher digits, propagating through 9s.
  - dec on 0 sets the digit to 9 and borrows through 0s.
  - Carry/borrow out of DIGITS-1 is discarded, so all-9s+1 = all-0s and all-0s-1 = all-9s.
  - Digits below the cursor are untouched.
- Undefined: per-digit wrap only, as described under Behaviour.

Decomposition:
- Package digit_entry_pkg holds:
  - the SEG_BLANK constant (8'hFF),
  - the 10-entry segment code constants,
  - the BCD_MAX=9 constant,
  - the bcd_inc/bcd_dec functions.
- One natural sub-module, seg7_decode: combinational 4-bit BCD → 8-bit active-low segments; values >9 decode to blank.

Test Plan (sim with SCAN_DIV=4, BLINK_TICKS=2, DIGITS=8):
- Reset, then hold 3 cycles → value=0, cursor=0, an=8'hFE, seg=8'hC0 on the first cycle after release.
- en=1, three btn_inc rises at cursor 0 → value[3:0]=3. Holding btn_inc high for 20 cycles → no further change.
- btn_right at cursor 0 → cursor=7. btn_left+btn_right in the same cycle → cursor unchanged. btn_inc+btn_dec in the same cycle → value unchanged.
- load with load_value=32'h1234_5A78 → value=32'h1234_5078. load plus btn_inc in the same cycle → load wins.
- Scan and blink:
  - Observe 64 cycles: an walks FE,FD,…,7F and changes every 4 cycles.
  - The cursor digit's seg is FF during alternate 8-cycle windows.
  - With en=0, no blanking occurs.
- With DIGIT_CARRY_EN: value=32'h0000_0999, cursor 0, inc → 32'h0000_1000. value=0, dec → 32'h9999_9999. Without the macro: 999 inc → 990.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared constants and BCD helpers for the digit entry/display block.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package digit_entry_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > BCD_MAX) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/digit_entry_display_seg7_decode.sv
// BCD to active-low 7-segment decoder; non-BCD codes blank.
// Decimal point is always off.
module seg7_decode
  import digit_entry_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_entry_display.sv
// Cursor-edited BCD register with multiplexed, blinking 7-seg output.
// Define DIGIT_CARRY_EN for decimal carry/borrow on inc/dec.
module digit_entry_display
  import digit_entry_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 262144,
  parameter int BLINK_TICKS = 64
) (
  input  logic                       clk100mhz,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_inc,
  input  logic                       btn_dec,
  input  logic                       load,
  input  logic [4*DIGITS-1:0]        load_value,
  output logic [4*DIGITS-1:0]        value,
  output logic [$clog2(DIGITS)-1:0]  cursor,
  output logic [DIGITS-1:0]          an,
  output logic [7:0]                 seg
);

  localparam int CW = $clog2(DIGITS);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int VW = 4 * DIGITS;
  localparam logic [CW-1:0] CMAX = CW'(DIGITS - 1);

  logic [VW-1:0]     value_q, value_d;
  logic [CW-1:0]     cursor_q, cursor_d;
  logic [3:0]        prev_q;
  logic [TW-1:0]     tick_q, tick_d;
  logic [CW-1:0]     scan_q, scan_d;
  logic [BW-1:0]     blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic [3:0]    btn, edg;
  logic          e_l, e_r, e_i, e_d;
  logic [VW-1:0] inc_v, dec_v, load_v;
  logic          tick;
  logic [3:0]    scan_digit;
  logic [7:0]    scan_seg;

  assign btn = {btn_left, btn_right, btn_inc, btn_dec};
  // Edges are dropped while disabled, but prev_q keeps tracking.
  assign edg = btn & ~prev_q & {4{en}};
  assign {e_l, e_r, e_i, e_d} = edg;

  always_comb begin
    load_v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] <= BCD_MAX)
        load_v[4*i +: 4] = load_value[4*i +: 4];
    end
  end

  always_comb begin
`ifdef DIGIT_CARRY_EN
    logic c_inc, c_dec;
    c_inc = 1'b1;
    c_dec = 1'b1;
`endif
    inc_v = value_q;
    dec_v = value_q;
    for (int i = 0; i < DIGITS; i++) begin
`ifdef DIGIT_CARRY_EN
      if (i >= int'(cursor_q) && c_inc) begin
        inc_v[4*i +: 4] = bcd_inc(value_q[4*i +: 4]);
        c_inc = (value_q[4*i +: 4] == BCD_MAX);
      end
      if (i >= int'(cursor_q) && c_dec) begin
        dec_v[4*i +: 4] = bcd_dec(value_q[4*i +: 4]);
        c_dec = (value_q[4*i +: 4] == 4'd0);
      end
`else
      if (i == int'(cursor_q)) begin
        inc_v[4*i +: 4] = bcd_inc(value_q[4*i +: 4]);
        dec_v[4*i +: 4] = bcd_dec(value_q[4*i +: 4]);
      end
`endif
    end
  end

  always_comb begin
    value_d  = value_q;
    cursor_d = cursor_q;
    if (load) begin
      value_d = load_v;
    end else begin
      if (e_i && !e_d)
        value_d = inc_v;
      else if (e_d && !e_i)
        value_d = dec_v;
      if (e_l && !e_r)
        cursor_d = (cursor_q == CMAX) ? '0 : cursor_q + CW'(1);
      else if (e_r && !e_l)
        cursor_d = (cursor_q == '0) ? CMAX : cursor_q - CW'(1);
    end
  end

  assign tick = (tick_q == TW'(SCAN_DIV - 1));

  always_comb begin
    tick_d  = tick ? '0 : tick_q + TW'(1);
    scan_d  = scan_q;
    blink_d = blink_q;
    phase_d = phase_q;
    if (tick) begin
      scan_d = (scan_q == CMAX) ? '0 : scan_q + CW'(1);
      if (blink_q == BW'(BLINK_TICKS - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end
  end

  assign scan_digit = value_q[{scan_q, 2'b00} +: 4];

  seg7_decode u_dec (
    .bcd_i (scan_digit),
    .seg_o (scan_seg)
  );

  always_comb begin
    an_d = '1;
    for (int i = 0; i < DIGITS; i++)
      an_d[i] = (CW'(i) != scan_q);
    seg_d = scan_seg;
    if (en && !phase_q && scan_q == cursor_q)
      seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      value_q  <= '0;
      cursor_q <= '0;
      prev_q   <= '0;
      tick_q   <= '0;
      scan_q   <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b1;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      value_q  <= value_d;
      cursor_q <= cursor_d;
      prev_q   <= btn;
      tick_q   <= tick_d;
      scan_q   <= scan_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign value  = value_q;
  assign cursor = cursor_q;
  assign an     = an_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_digit_entry_display.sv
// Directed bench for digit_entry_display (DIGITS=8, SCAN_DIV=4, BLINK_TICKS=2).
// Build with +define+DIGIT_CARRY_EN to check the carry variant.
module tb_digit_entry_display;

  logic        clk;
  logic        rst, en, load;
  logic        btn_left, btn_right, btn_inc, btn_dec;
  logic [31:0] load_value;
  logic [31:0] value;
  logic [2:0]  cursor;
  logic [7:0]  an, seg;

  int n_chk;
  int n_fail;

  logic [7:0] segc [10];

  digit_entry_display #(
    .DIGITS      (8),
    .SCAN_DIV    (4),
    .BLINK_TICKS (2)
  ) dut (
    .clk100mhz  (clk),
    .rst        (rst),
    .en         (en),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .load       (load),
    .load_value (load_value),
    .value      (value),
    .cursor     (cursor),
    .an         (an),
    .seg        (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // b = {left, right, inc, dec}
  task automatic pulse(input logic [3:0] b);
    {btn_left, btn_right, btn_inc, btn_dec} = b;
    step();
    {btn_left, btn_right, btn_inc, btn_dec} = 4'b0;
    step();
  endtask

  task automatic do_load(input logic [31:0] v);
    load_value = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int t, d;
    logic off;
    logic [7:0] e_an, e_seg;

    segc[0] = 8'hC0; segc[1] = 8'hF9; segc[2] = 8'hA4;
    segc[3] = 8'hB0; segc[4] = 8'h99; segc[5] = 8'h92;
    segc[6] = 8'h82; segc[7] = 8'hF8; segc[8] = 8'h80;
    segc[9] = 8'h90;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; load_value = '0;
    {btn_left, btn_right, btn_inc, btn_dec} = 4'b0;

    repeat (3) step();
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    rst = 1'b0;
    step();
    chk("rel_an", {24'h0, an}, 32'hFE);
    chk("rel_seg", {24'h0, seg}, 32'hC0);
    chk("rel_value", value, 32'h0);
    chk("rel_cursor", {29'h0, cursor}, 32'h0);

    en = 1'b1;
    btn_inc = 1'b1;
    step();
    chk("inc_latency", value, 32'h1);
    btn_inc = 1'b0;
    step();
    pulse(4'b0010);
    pulse(4'b0010);
    chk("inc3", value, 32'h3);
    btn_inc = 1'b1;
    repeat (20) step();
    chk("inc_hold", value, 32'h4);
    btn_inc = 1'b0;
    step();

    pulse(4'b0100);
    chk("right_wrap", {29'h0, cursor}, 32'h7);
    pulse(4'b1100);
    chk("left_right", {29'h0, cursor}, 32'h7);
    pulse(4'b0011);
    chk("inc_dec", value, 32'h4);
    pulse(4'b0001);
    chk("dec_wrap", value, 32'h9000_0004);
    pulse(4'b1000);
    chk("left_wrap", {29'h0, cursor}, 32'h0);
    pulse(4'b1010);
    chk("move_inc_val", value, 32'h9000_0005);
    chk("move_inc_cur", {29'h0, cursor}, 32'h1);

    en = 1'b0;
    btn_inc = 1'b1;
    repeat (3) step();
    chk("en0_ignore", value, 32'h9000_0005);
    en = 1'b1;
    repeat (3) step();
    chk("en_rise_held", value, 32'h9000_0005);
    btn_inc = 1'b0;
    step();

    do_load(32'h1234_5A78);
    chk("load_clean", value, 32'h1234_5078);
    chk("load_cursor", {29'h0, cursor}, 32'h1);
    btn_inc = 1'b1;
    do_load(32'h0000_0011);
    chk("load_wins", value, 32'h0000_0011);
    btn_inc = 1'b0;
    step();
    chk("load_wins_after", value, 32'h0000_0011);
    do_load(32'hFFFF_FFFF);
    chk("load_all_bad", value, 32'h0);

    pulse(4'b0100);
    do_load(32'h0000_0999);
    pulse(4'b0010);
`ifdef DIGIT_CARRY_EN
    chk("carry_inc", value, 32'h0000_1000);
`else
    chk("wrap_inc", value, 32'h0000_0990);
`endif
    do_load(32'h0);
    pulse(4'b0001);
`ifdef DIGIT_CARRY_EN
    chk("borrow_dec", value, 32'h9999_9999);
`else
    chk("wrap_dec", value, 32'h0000_0009);
`endif

    // Scan/blink: k counts edges since reset release.
    rst = 1'b1;
    step();
    rst = 1'b0;
    en = 1'b1;
    load_value = 32'h7654_3210;
    load = 1'b1;
    step();
    load = 1'b0;
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    chk("scan_cursor", {29'h0, cursor}, 32'h7);
    for (int k = 3; k <= 130; k++) begin
      en = (k <= 66);
      step();
      t = (k - 1) / 4;
      d = t % 8;
      off = ((t / 2) % 2) == 1;
      e_an = ~(8'h01 << d);
      e_seg = (en && off && d == 7) ? 8'hFF : segc[d];
      chk("scan_an", {24'h0, an}, {24'h0, e_an});
      chk("scan_seg", {24'h0, seg}, {24'h0, e_seg});
    end
    en = 1'b1;

    pulse(4'b0010);
    rst = 1'b1;
    btn_inc = 1'b1;
    step();
    chk("mid_rst_val", value, 32'h0);
    chk("mid_rst_cur", {29'h0, cursor}, 32'h0);
    chk("mid_rst_an", {24'h0, an}, 32'hFF);
    rst = 1'b0;
    btn_inc = 1'b0;
    step();
    chk("post_rst_val", value, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
